// File: rtl/led_scan_capture_if.sv
// Scan-bus observation and frame-buffer read signals for led_scan_capture.
// slave is the monitor; master drives the scan bus and reads the buffer.
interface led_scan_capture_if;
  logic [15:0] led_r;
  logic [15:0] led_c;
  logic        err_clr;
  logic [3:0]  rd_row;
  logic [15:0] rd_data;
  logic        frame_valid;
  logic [7:0]  frame_cnt;
  logic [8:0]  lit_cnt;
  logic        scan_err;

  modport master (
    output led_r, led_c, err_clr, rd_row,
    input  rd_data, frame_valid, frame_cnt, lit_cnt, scan_err
  );

  modport slave (
    input  led_r, led_c, err_clr, rd_row,
    output rd_data, frame_valid, frame_cnt, lit_cnt, scan_err
  );
endinterface

// File: rtl/led_scan_capture.sv
// Passive LED-matrix scan monitor: de-glitches each row dwell, rebuilds 16x16
// frames, and exposes the last committed frame through a registered read port.
module led_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 65535
) (
  input  logic              clk,
  input  logic              reset,
  led_scan_capture_if.slave bus
);

  localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [19:0] IDLE_MAX    = 20'(TIMEOUT);

  logic [15:0] prev_r_q;
  logic [15:0] prev_c_q;
  logic [7:0]  stable_cnt_q, stable_cnt_d;
  logic        armed_q, armed_d;
  logic [19:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] seen_q, seen_d;
  logic        commit_q, commit_d;
  logic [15:0] work_q  [16];
  logic [15:0] frame_q [16];
  logic [15:0] rd_data_q;
  logic        frame_valid_q;
  logic [7:0]  frame_cnt_q;
  logic [8:0]  lit_cnt_q, lit_cnt_d;
  logic        scan_err_q, scan_err_d;

  logic        same_sample;
  logic        capture;
  logic        row_onehot;
  logic        row_multi;
  logic        cap_row;
  logic        timed_out;
  logic [3:0]  row_idx;

  // Row decode of the live sample; it equals the previous sample on any capture edge.
  assign row_onehot = (bus.led_r != 16'd0) && ((bus.led_r & (bus.led_r - 16'd1)) == 16'd0);
  assign row_multi  = (bus.led_r != 16'd0) && !row_onehot;

  always_comb begin
    row_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (bus.led_r[i]) row_idx = 4'(i);
    end
  end

  assign same_sample = (bus.led_r == prev_r_q) && (bus.led_c == prev_c_q);

  always_comb begin
    stable_cnt_d = 8'd0;
    if (same_sample) begin
      stable_cnt_d = (stable_cnt_q == 8'hFF) ? stable_cnt_q : stable_cnt_q + 8'd1;
    end
  end

  // armed limits each dwell to a single capture, however long it lasts.
  assign capture = armed_q && (stable_cnt_d == STABLE_LAST);
  assign cap_row = capture && row_onehot;

  always_comb begin
    armed_d = armed_q;
    if (!same_sample) begin
      armed_d = 1'b1;
    end else if (capture) begin
      armed_d = 1'b0;
    end
  end

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (cap_row) begin
      idle_cnt_d = 20'd0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + 20'd1;
    end
  end

  assign timed_out = !cap_row && (idle_cnt_d == IDLE_MAX);

  // A row captured on the commit edge belongs to the next frame, so it is
  // OR-ed in after the clear.
  always_comb begin
    seen_d = seen_q;
    if (commit_q || timed_out) begin
      seen_d = 16'd0;
    end
    if (cap_row) begin
      seen_d = seen_d | bus.led_r;
    end
  end

  assign commit_d   = cap_row && (&seen_d);
  assign scan_err_d = (capture && row_multi) || (scan_err_q && !bus.err_clr);

  // work_q already holds the completing row when the commit edge arrives.
  always_comb begin
    lit_cnt_d = 9'd0;
    for (int i = 0; i < 16; i++) begin
      lit_cnt_d = lit_cnt_d + 9'($countones(work_q[i]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r_q      <= 16'd0;
      prev_c_q      <= 16'd0;
      stable_cnt_q  <= 8'd0;
      armed_q       <= 1'b1;
      idle_cnt_q    <= 20'd0;
      seen_q        <= 16'd0;
      commit_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
      lit_cnt_q     <= 9'd0;
      scan_err_q    <= 1'b0;
      rd_data_q     <= 16'd0;
    end else begin
      prev_r_q      <= bus.led_r;
      prev_c_q      <= bus.led_c;
      stable_cnt_q  <= stable_cnt_d;
      armed_q       <= armed_d;
      idle_cnt_q    <= idle_cnt_d;
      seen_q        <= seen_d;
      commit_q      <= commit_d;
      frame_valid_q <= commit_q;
      scan_err_q    <= scan_err_d;
      rd_data_q     <= frame_q[bus.rd_row];
      if (commit_q) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        lit_cnt_q   <= lit_cnt_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        work_q[i]  <= 16'd0;
        frame_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (cap_row && (row_idx == 4'(i))) begin
          work_q[i] <= ~bus.led_c;
        end
        if (commit_q) begin
          frame_q[i] <= work_q[i];
        end
      end
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.lit_cnt     = lit_cnt_q;
  assign bus.scan_err    = scan_err_q;

endmodule
